// File: rtl/saver_pkg.sv
// Shared types and constants for the SD-card image saver.
// Covers the FSM state encoding, the sector geometry and the target-select decode.
package saver_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int IDX_W        = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL_REQ,
        S_FILL_CAP,
        S_WR_REQ,
        S_WR_WAIT,
        S_NEXT,
        S_FINISH
    } state_t;

    // One 3-bit sd_wr pattern per save_sel value, LSB group = sel 0; sel 3 maps to nothing.
    localparam logic [11:0] SEL_WR_MAP  = {3'b000, 3'b100, 3'b010, 3'b001};
    localparam logic [1:0]  SEL_INVALID = 2'd3;

    function automatic logic [2:0] sel_to_wr(input logic [1:0] sel);
        return SEL_WR_MAP[int'(sel) * 3 +: 3];
    endfunction

endpackage

// File: rtl/saver_sd_card_if.sv
// Bus bundle between the saver, the core's ioctl upload port and the shared SD controller.
// sd_wr is a level request held until sd_busy acknowledges it, and sd_done ends the sector;
// ioctl_rd is a one-cycle strobe that is never raised while ioctl_wait is high, and
// ioctl_din answers it on the following cycle.
interface saver_sd_card_if #(
    parameter int ADDR_W = 23
);
    logic              save_req;
    logic [1:0]        save_sel;
    logic [ADDR_W-1:0] save_size;
    logic [31:0]       sd_lba;
    logic [2:0]        sd_wr;
    logic              sd_busy;
    logic              sd_done;
    logic [8:0]        sd_byte_index;
    logic [7:0]        sd_wr_data;
    logic              ioctl_upload;
    logic [ADDR_W-1:0] ioctl_addr;
    logic              ioctl_rd;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic              saver_busy;
    logic              save_done;

    modport master (
        input  save_req, save_sel, save_size, sd_busy, sd_done, sd_byte_index,
               ioctl_din, ioctl_wait,
        output sd_lba, sd_wr, sd_wr_data, ioctl_upload, ioctl_addr, ioctl_rd,
               saver_busy, save_done
    );

    modport slave (
        output save_req, save_sel, save_size, sd_busy, sd_done, sd_byte_index,
               ioctl_din, ioctl_wait,
        input  sd_lba, sd_wr, sd_wr_data, ioctl_upload, ioctl_addr, ioctl_rd,
               saver_busy, save_done
    );
endinterface

// File: rtl/sector_buffer_dp.sv
// 512x8 simple dual-port sector buffer: write port fed by the fill path,
// registered read port addressed by the SD controller's byte index.
module sector_buffer_dp
    import saver_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a_we,
    input  logic [IDX_W-1:0] a_addr,
    input  logic [7:0]       a_wdata,
    input  logic [IDX_W-1:0] b_addr,
    output logic [7:0]       b_rdata
);
    logic [7:0] mem [SECTOR_BYTES];
    logic [7:0] b_rdata_q;

    always_ff @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_wdata;
    end

    // Output register carries the reset so the read data reads 0 after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) b_rdata_q <= '0;
        else          b_rdata_q <= mem[b_addr];
    end

    assign b_rdata = b_rdata_q;
endmodule

// File: rtl/saver_sd_card.sv
// Reads an image back from the core over ioctl, stages it a sector at a time,
// and writes the sectors to the selected SD image starting at LBA 0.
module saver_sd_card
    import saver_pkg::*;
#(
    parameter int ADDR_W = 23
) (
    input  logic            clk,
    input  logic            reset_n,
    saver_sd_card_if.master bus,
    output state_t          dbg_state
);
    state_t            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [ADDR_W-1:0] size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       lba_q, lba_d;
    logic [31:0]       sd_lba_q, sd_lba_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        sd_wr_q, sd_wr_d;
    logic              upload_q, upload_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ioctl_rd;
    logic              buf_we;
    logic [7:0]        buf_wdata;
    logic [7:0]        buf_rdata;
    logic              req_ok, addr_done, sector_full;

    assign req_ok      = bus.save_sel != SEL_INVALID && bus.save_size != '0;
    assign addr_done   = addr_q >= size_q;
    assign sector_full = cnt_q == IDX_W'(SECTOR_BYTES - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (bus.save_req && req_ok) state_d = S_FILL_REQ;
            S_FILL_REQ: begin
                if (addr_done)            state_d = sector_full ? S_WR_REQ : S_FILL_REQ;
                else if (!bus.ioctl_wait) state_d = S_FILL_CAP;
            end
            S_FILL_CAP: state_d = sector_full ? S_WR_REQ : S_FILL_REQ;
            S_WR_REQ:   state_d = S_WR_WAIT;
            S_WR_WAIT:  if (bus.sd_done) state_d = S_NEXT;
            S_NEXT:     state_d = addr_done ? S_FINISH : S_FILL_REQ;
            S_FINISH:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // ioctl_rd is issued from FILL_REQ itself so the byte is back in FILL_CAP (2 cycles/byte).
    always_comb begin
        sel_d     = sel_q;
        size_d    = size_q;
        addr_d    = addr_q;
        lba_d     = lba_q;
        cnt_d     = cnt_q;
        sd_lba_d  = sd_lba_q;
        sd_wr_d   = bus.sd_busy ? 3'b000 : sd_wr_q;
        upload_d  = upload_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ioctl_rd  = 1'b0;
        buf_we    = 1'b0;
        buf_wdata = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (bus.save_req && req_ok) begin
                    sel_d    = bus.save_sel;
                    size_d   = bus.save_size;
                    addr_d   = '0;
                    lba_d    = '0;
                    cnt_d    = '0;
                    upload_d = 1'b1;
                    busy_d   = 1'b1;
                end else if (bus.save_req) begin
                    done_d = 1'b1;
                end
            end
            S_FILL_REQ: begin
                if (addr_done) begin
                    buf_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end else if (!bus.ioctl_wait) begin
                    ioctl_rd = 1'b1;
                end
            end
            S_FILL_CAP: begin
                buf_we    = 1'b1;
                buf_wdata = bus.ioctl_din;
                addr_d    = addr_q + 1'b1;
                cnt_d     = cnt_q + 1'b1;
            end
            S_WR_REQ: begin
                sd_lba_d = lba_q;
                sd_wr_d  = sel_to_wr(sel_q);
            end
            S_NEXT: begin
                lba_d = lba_q + 32'd1;
                cnt_d = '0;
            end
            S_FINISH: begin
                upload_d = 1'b0;
                busy_d   = 1'b0;
                addr_d   = '0;
                done_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q    <= '0;
            size_q   <= '0;
            addr_q   <= '0;
            lba_q    <= '0;
            cnt_q    <= '0;
            sd_lba_q <= '0;
            sd_wr_q  <= '0;
            upload_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            sel_q    <= sel_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            lba_q    <= lba_d;
            cnt_q    <= cnt_d;
            sd_lba_q <= sd_lba_d;
            sd_wr_q  <= sd_wr_d;
            upload_q <= upload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    sector_buffer_dp u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .a_we    (buf_we),
        .a_addr  (cnt_q),
        .a_wdata (buf_wdata),
        .b_addr  (bus.sd_byte_index),
        .b_rdata (buf_rdata)
    );

    assign bus.sd_lba       = sd_lba_q;
    assign bus.sd_wr        = sd_wr_q;
    assign bus.sd_wr_data   = buf_rdata;
    assign bus.ioctl_upload = upload_q;
    assign bus.ioctl_addr   = addr_q;
    assign bus.ioctl_rd     = ioctl_rd;
    assign bus.saver_busy   = busy_q;
    assign bus.save_done    = done_q;
    assign dbg_state        = state_q;
endmodule

// File: tb/tb_saver_sd_card.sv
// Bench for saver_sd_card: core memory and SD controller models, with a byte
// scoreboard filled when a save is requested and drained by sector readback.
module tb_saver_sd_card;
    import saver_pkg::*;

    localparam int ADDR_W = 23;

    logic   clk = 1'b0;
    logic   reset_n = 1'b0;
    state_t dbg_state;

    always #5 clk = ~clk;

    saver_sd_card_if #(.ADDR_W(ADDR_W)) bus ();

    saver_sd_card #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int               n_checks = 0;
    int               n_fail = 0;
    logic [7:0]       core_mem [2048];
    logic [7:0]       exp_q [$];
    logic [ADDR_W-1:0] rd_log [$];
    int               rd_during_wait = 0;
    int               done_cnt = 0;
    int               wr_rise = 0;
    logic [2:0]       sd_wr_prev = 3'b000;

    // Core model: answers each read strobe one cycle later; also logs bus events.
    always @(posedge clk) begin
        if (bus.ioctl_rd === 1'b1) begin
            rd_log.push_back(bus.ioctl_addr);
            if (bus.ioctl_wait) rd_during_wait++;
            bus.ioctl_din <= core_mem[bus.ioctl_addr[10:0]];
        end
        if (bus.save_done === 1'b1) done_cnt++;
        if (bus.sd_wr != 3'b000 && sd_wr_prev == 3'b000) wr_rise++;
        sd_wr_prev <= bus.sd_wr;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic load_core(input int size, input bit ramp);
        for (int i = 0; i < 2048; i++)
            core_mem[i] = ramp ? 8'(i) : 8'($urandom_range(0, 255));
        exp_q.delete();
        rd_log.delete();
        for (int i = 0; i < ((size + 511) / 512) * 512; i++)
            exp_q.push_back(i < size ? core_mem[i] : 8'h00);
    endtask

    task automatic drive_save_req(input logic [1:0] sel, input int size);
        @(negedge clk);
        bus.save_req  = 1'b1;
        bus.save_sel  = sel;
        bus.save_size = ADDR_W'(size);
        @(negedge clk);
        bus.save_req  = 1'b0;
    endtask

    function automatic int addr_gaps();
        int g = 0;
        foreach (rd_log[i]) if (rd_log[i] !== ADDR_W'(i)) g++;
        return g;
    endfunction

    task automatic wait_save_done(output bit seen);
        int t = 0;
        seen = 1'b0;
        while (!seen && t < 200) begin
            @(negedge clk);
            t++;
            if (bus.save_done === 1'b1) seen = 1'b1;
        end
    endtask

    // SD controller model: accept one sector write, read it back, drain the scoreboard.
    task automatic serve_sector(input logic [2:0] exp_wr, input int exp_lba, input int busy_delay);
        int t = 0;
        int held = 0;
        int bad = 0;
        int first = -1;
        logic [7:0] fg, fw, want;
        fg = 8'h00;
        fw = 8'h00;
        while (bus.sd_wr === 3'b000 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (bus.sd_wr === 3'b000) begin
            n_fail++;
            $display("FAIL sd_wr_timeout: sd_wr stayed 000 for %0d cycles, required %b", t, exp_wr);
            return;
        end
        n_checks++;
        if (bus.sd_wr !== exp_wr) begin
            n_fail++;
            $display("FAIL sd_wr_target: got %b required %b", bus.sd_wr, exp_wr);
        end
        n_checks++;
        if (bus.sd_lba !== 32'(exp_lba)) begin
            n_fail++;
            $display("FAIL sd_lba: got %0d required %0d", bus.sd_lba, exp_lba);
        end
        for (int i = 0; i < busy_delay; i++) begin
            @(negedge clk);
            if (bus.sd_wr === exp_wr) held++;
        end
        if (busy_delay > 0) begin
            n_checks++;
            if (held != busy_delay) begin
                n_fail++;
                $display("FAIL sd_wr_hold: held %0d cycles required %0d", held, busy_delay);
            end
        end
        bus.sd_busy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.sd_wr !== 3'b000) begin
            n_fail++;
            $display("FAIL sd_wr_clear: got %b after sd_busy, required 000", bus.sd_wr);
        end
        for (int k = 0; k < 512; k++) begin
            bus.sd_byte_index = 9'(k);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                bad++;
                if (first < 0) begin first = k; fg = bus.sd_wr_data; fw = 8'h00; end
            end else begin
                want = exp_q.pop_front();
                if (bus.sd_wr_data !== want) begin
                    bad++;
                    if (first < 0) begin first = k; fg = bus.sd_wr_data; fw = want; end
                end
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sector_data: lba %0d has %0d bad bytes, first idx %0d got %h required %h",
                     exp_lba, bad, first, fg, fw);
        end
        bus.sd_busy = 1'b0;
        bus.sd_done = 1'b1;
        @(negedge clk);
        bus.sd_done = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.sd_wr, bus.ioctl_upload, bus.ioctl_rd, bus.saver_busy, bus.save_done} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 0", {bus.sd_wr, bus.ioctl_upload, bus.ioctl_rd,
                     bus.saver_busy, bus.save_done});
        end
        n_checks++;
        if (bus.sd_lba !== 32'd0 || bus.ioctl_addr !== '0 || bus.sd_wr_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: lba %h addr %h data %h required all 0", bus.sd_lba, bus.ioctl_addr,
                     bus.sd_wr_data);
        end
        n_checks++;
        if (dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d required %0d", dbg_state, S_IDLE);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_sector();
        int d0 = done_cnt;
        int w0 = wr_rise;
        bit seen;
        load_core(512, 1'b1);
        drive_save_req(2'd0, 512);
        n_checks++;
        if (bus.saver_busy !== 1'b1 || bus.ioctl_upload !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: busy %b upload %b required 1 1", bus.saver_busy, bus.ioctl_upload);
        end
        serve_sector(3'b001, 0, 0);
        wait_save_done(seen);
        n_checks++;
        if (!seen || bus.saver_busy !== 1'b0 || bus.ioctl_upload !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: seen %b busy %b upload %b required 1 0 0", seen, bus.saver_busy,
                     bus.ioctl_upload);
        end
        n_checks++;
        if (rd_log.size() != 512 || addr_gaps() != 0) begin
            n_fail++;
            $display("FAIL basic_reads: %0d reads, %0d gaps, required 512 reads 0 gaps", rd_log.size(),
                     addr_gaps());
        end
        @(negedge clk);
        n_checks++;
        if (done_cnt - d0 != 1 || wr_rise - w0 != 1) begin
            n_fail++;
            $display("FAIL basic_counts: done %0d writes %0d required 1 1", done_cnt - d0, wr_rise - w0);
        end
    endtask

    task automatic test_multi_sector();
        int d0 = done_cnt;
        int w0 = wr_rise;
        bit seen;
        load_core(700, 1'b0);
        drive_save_req(2'd2, 700);
        serve_sector(3'b100, 0, 0);
        serve_sector(3'b100, 1, 0);
        wait_save_done(seen);
        @(negedge clk);
        n_checks++;
        if (rd_log.size() != 700 || addr_gaps() != 0) begin
            n_fail++;
            $display("FAIL multi_reads: %0d reads, %0d gaps, required 700 reads 0 gaps", rd_log.size(),
                     addr_gaps());
        end
        n_checks++;
        if (!seen || done_cnt - d0 != 1 || wr_rise - w0 != 2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL multi_counts: seen %b done %0d writes %0d left %0d required 1 1 2 0", seen,
                     done_cnt - d0, wr_rise - w0, exp_q.size());
        end
    endtask

    task automatic test_ioctl_wait();
        int stall_at [2] = '{100, 350};
        int t, n, grow;
        bit seen;
        load_core(512, 1'b0);
        rd_during_wait = 0;
        drive_save_req(2'd1, 512);
        for (int s = 0; s < 2; s++) begin
            t = 0;
            while (rd_log.size() < stall_at[s] && t < 3000) begin
                @(negedge clk);
                t++;
            end
            bus.ioctl_wait = 1'b1;
            n = rd_log.size();
            repeat (10) @(negedge clk);
            grow = rd_log.size() - n;
            bus.ioctl_wait = 1'b0;
            n_checks++;
            if (grow != 0 || n < stall_at[s]) begin
                n_fail++;
                $display("FAIL wait_stall%0d: %0d reads during stall at count %0d, required 0 at >= %0d",
                         s, grow, n, stall_at[s]);
            end
        end
        serve_sector(3'b010, 0, 0);
        wait_save_done(seen);
        n_checks++;
        if (!seen || rd_during_wait != 0 || rd_log.size() != 512 || addr_gaps() != 0) begin
            n_fail++;
            $display("FAIL wait_reads: seen %b rd_in_wait %0d reads %0d gaps %0d required 1 0 512 0",
                     seen, rd_during_wait, rd_log.size(), addr_gaps());
        end
    endtask

    task automatic test_sd_busy_delay();
        int w0 = wr_rise;
        bit seen;
        load_core(512, 1'b0);
        drive_save_req(2'd0, 512);
        repeat (5) @(negedge clk);
        bus.sd_done = 1'b1;
        @(negedge clk);
        bus.sd_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if ((dbg_state !== S_FILL_REQ && dbg_state !== S_FILL_CAP) || bus.saver_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_done: state %0d busy %b required fill state, busy 1", dbg_state,
                     bus.saver_busy);
        end
        serve_sector(3'b001, 0, 20);
        wait_save_done(seen);
        @(negedge clk);
        n_checks++;
        if (!seen || wr_rise - w0 != 1 || rd_log.size() != 512 || addr_gaps() != 0) begin
            n_fail++;
            $display("FAIL busy_delay_counts: seen %b writes %0d reads %0d gaps %0d required 1 1 512 0",
                     seen, wr_rise - w0, rd_log.size(), addr_gaps());
        end
    endtask

    task automatic test_reset_abort();
        int t = 0;
        int d0;
        int w0;
        bit seen;
        load_core(1024, 1'b0);
        core_mem[0] = 8'hA5;
        bus.sd_byte_index = 9'd0;
        drive_save_req(2'd1, 1024);
        while (bus.sd_wr === 3'b000 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (dbg_state !== S_WR_WAIT || bus.sd_wr !== 3'b010 || bus.sd_wr_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL abort_pre: state %0d sd_wr %b data %h required %0d 010 a5", dbg_state,
                     bus.sd_wr, bus.sd_wr_data, S_WR_WAIT);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.sd_wr, bus.ioctl_upload, bus.ioctl_rd, bus.saver_busy, bus.save_done} !== 7'b0 ||
            bus.ioctl_addr !== '0 || bus.sd_wr_data !== 8'h00 || dbg_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL abort_outputs: sd_wr %b upload %b busy %b addr %h data %h state %0d required 0",
                     bus.sd_wr, bus.ioctl_upload, bus.saver_busy, bus.ioctl_addr, bus.sd_wr_data, dbg_state);
        end
        @(negedge clk);
        reset_n = 1'b1;
        d0 = done_cnt;
        w0 = wr_rise;
        repeat (20) @(negedge clk);
        n_checks++;
        if (done_cnt != d0 || wr_rise != w0 || bus.saver_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_quiet: done %0d writes %0d busy %b required 0 0 0", done_cnt - d0,
                     wr_rise - w0, bus.saver_busy);
        end
        load_core(600, 1'b0);
        drive_save_req(2'd1, 600);
        serve_sector(3'b010, 0, 0);
        serve_sector(3'b010, 1, 0);
        wait_save_done(seen);
        @(negedge clk);
        n_checks++;
        if (!seen || done_cnt - d0 != 1 || rd_log.size() != 600 || addr_gaps() != 0) begin
            n_fail++;
            $display("FAIL abort_resave: seen %b done %0d reads %0d gaps %0d required 1 1 600 0", seen,
                     done_cnt - d0, rd_log.size(), addr_gaps());
        end
    endtask

    task automatic test_edge_requests();
        logic [1:0] sels [2] = '{2'd0, 2'd3};
        int         sizes [2] = '{0, 100};
        int d0, w0;
        bit seen;
        for (int e = 0; e < 2; e++) begin
            rd_log.delete();
            d0 = done_cnt;
            w0 = wr_rise;
            drive_save_req(sels[e], sizes[e]);
            n_checks++;
            if (bus.save_done !== 1'b1 || bus.saver_busy !== 1'b0 || bus.ioctl_upload !== 1'b0) begin
                n_fail++;
                $display("FAIL edge%0d_pulse: done %b busy %b upload %b required 1 0 0", e, bus.save_done,
                         bus.saver_busy, bus.ioctl_upload);
            end
            repeat (10) @(negedge clk);
            n_checks++;
            if (rd_log.size() != 0 || wr_rise != w0 || done_cnt - d0 != 1 || dbg_state !== S_IDLE) begin
                n_fail++;
                $display("FAIL edge%0d_quiet: reads %0d writes %0d done %0d state %0d required 0 0 1 idle",
                         e, rd_log.size(), wr_rise - w0, done_cnt - d0, dbg_state);
            end
        end
        load_core(300, 1'b0);
        d0 = done_cnt;
        w0 = wr_rise;
        drive_save_req(2'd0, 300);
        repeat (20) @(negedge clk);
        drive_save_req(2'd1, 50);
        serve_sector(3'b001, 0, 0);
        wait_save_done(seen);
        @(negedge clk);
        n_checks++;
        if (!seen || done_cnt - d0 != 1 || wr_rise - w0 != 1 || rd_log.size() != 300 || addr_gaps() != 0) begin
            n_fail++;
            $display("FAIL edge_busy_req: seen %b done %0d writes %0d reads %0d gaps %0d required 1 1 1 300 0",
                     seen, done_cnt - d0, wr_rise - w0, rd_log.size(), addr_gaps());
        end
    endtask

    initial begin
        bus.save_req      = 1'b0;
        bus.save_sel      = 2'd0;
        bus.save_size     = '0;
        bus.sd_busy       = 1'b0;
        bus.sd_done       = 1'b0;
        bus.sd_byte_index = 9'd0;
        bus.ioctl_wait    = 1'b0;
        test_reset();
        test_basic_sector();
        test_multi_sector();
        test_ioctl_wait();
        test_sd_busy_delay();
        test_reset_abort();
        test_edge_requests();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/saver_sd_card.md
Name: saver_sd_card

Overview:
Write-direction counterpart of the SD-card image loader. On a save request it reads an image back from the core over an ioctl upload interface and stages it 512 bytes at a time in a sector buffer. It then issues SD sector writes to the selected mounted image, starting at image-relative LBA 0. It sits between the core's memory (cartridge RAM, snapshot, disk image) and the shared SD controller, next to the loader.

Parameters:
ADDR_W, 23, width of the image byte address and size.
SECTOR_BYTES, 512, sector size. Fixed: 9-bit byte index.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
save_req  in  1  one-cycle pulse; start a save
save_sel  in  2  target image 0..2; drives sd_wr[save_sel]; value 3 is invalid
save_size  in  ADDR_W  image size in bytes; sampled with save_req
sd_lba  out  32  image-relative sector number
sd_wr  out  3  write request per target
sd_busy  in  1  SD controller has accepted the request
sd_done  in  1  sector write complete
sd_byte_index  in  9  byte index the SD controller is fetching
sd_wr_data  out  8  buffer[sd_byte_index], registered, 1-cycle latency
ioctl_upload  out  1  high for the whole save
ioctl_addr  out  ADDR_W  byte address being read from the core
ioctl_rd  out  1  one-cycle read strobe
ioctl_din  in  8  core data; valid the cycle after ioctl_rd
ioctl_wait  in  1  core stall; no ioctl_rd is issued while high
saver_busy  out  1  high from accepted save_req until save_done
save_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, active-low): FSM goes to IDLE. All outputs are 0: sd_lba, sd_wr, ioctl_upload, ioctl_addr, ioctl_rd, saver_busy, save_done, sd_wr_data. Buffer contents are don't-care.
- States: IDLE, FILL_REQ, FILL_CAP, WR_REQ, WR_WAIT, NEXT, FINISH.
- IDLE:
  - save_req with save_sel<3 and save_size>0: latch sel and size; addr=0, lba=0, cnt=0; set saver_busy and ioctl_upload; go to FILL_REQ.
  - save_req with save_sel==3 or save_size==0: pulse save_done next cycle; no SD or ioctl activity; saver_busy stays 0.
  - save_req outside IDLE is ignored.
- FILL_REQ:
  - If addr>=size: write 0x00 to buf[cnt] with no core access, then advance cnt.
  - Else if ioctl_wait is low: ioctl_addr<=addr, ioctl_rd=1 for one cycle, go to FILL_CAP.
  - Else: hold.
- FILL_CAP: buf[cnt]<=ioctl_din; addr++, cnt++.
- Leaving the fill states: when the cnt wraps from 511 to 0 (sector full), go to WR_REQ; otherwise return to FILL_REQ.
- Throughput: a read byte costs 2 cycles minimum; a padded byte costs 1 cycle.
- WR_REQ: sd_lba<=lba; sd_wr[sel]<=1; go to WR_WAIT. sd_wr is cleared on the first cycle sd_busy is high and stays held until then.
- WR_WAIT: wait for sd_done. sd_done seen in any other state is ignored. During WR_WAIT the buffer is read-only; sd_wr_data follows sd_byte_index with 1-cycle latency.
- NEXT: lba++. If addr>=size go to FINISH, else go to FILL_REQ with cnt=0.
- FINISH: ioctl_upload<=0, saver_busy<=0, ioctl_addr<=0; pulse save_done; go to IDLE.
- Sector count is ceil(size/512). The tail of the last sector is zero-padded. Exactly `size` ioctl_rd strobes are issued, at addresses 0..size-1 in order.
- Arithmetic:
  - addr and size compare unsigned at ADDR_W bits.
  - lba is 32-bit with natural wrap (unreachable with a 23-bit size).
  - cnt is 9-bit; its wrap marks the sector boundary.
- Reset mid-operation (including while sd_wr is pending or in WR_WAIT): immediate abort. sd_wr drops asynchronously; a partial sector is not written; no save_done.

Decomposition:
- Shared package saver_pkg: state enum, SECTOR_BYTES, the target-to-sd_wr mapping constant (sel 3 = invalid).
- One sub-module, sector_buffer_dp: 512x8 simple dual-port RAM. Port A is the write port from the fill path. Port B is the registered read port addressed by sd_byte_index. It maps to Gowin block SRAM.

Test Plan:
- sel=0, size=512, ramp data i&0xFF, no stalls -> 512 ioctl_rd at addr 0..511; one sd_wr=3'b001 with sd_lba=0; SD readback of index k returns k&0xFF; one save_done; saver_busy low afterwards.
- sel=2, size=700 -> two writes with sd_wr=3'b100 at sd_lba 0 then 1; 700 reads total; sector 1 bytes 0..187 hold data, bytes 188..511 are 0x00.
- ioctl_wait high for 10 cycles mid-sector, twice -> no ioctl_rd while high; captured data unchanged and in order; address sequence has no gaps.
- sd_busy delayed 20 cycles after sd_wr -> sd_wr held high 20 cycles then cleared; sd_done arriving during FILL is ignored; the byte sequence is still correct.
- Reset asserted in WR_WAIT of sector 0 of a 1024-byte save -> all outputs 0 immediately, no save_done; a fresh save_req afterwards completes normally.
- Edge requests: save_req with size=0 -> save_done pulse only, no SD or ioctl activity; save_req with sel=3 -> same; a second save_req while busy -> ignored, first save finishes unchanged.
